pila_retorno: RTL and testbench

Hardware return-address stack for the simple 8-bit processor.
- On CALL it stores the incremented program counter produced by the PC adder (PC+1).
- On RET it presents the saved address to the PC source mux.
- Sits directly downstream of the PC adder and upstream of the PC register.
- LIFO with occupancy count, full/empty status and sticky overflow/underflow error flags for the control unit.

---
 rtl/pila_pkg.sv | 14 +
 rtl/pila_mem.sv | 19 +
 rtl/pila_retorno.sv | 88 ++++++++
 tb/tb_pila_retorno.sv | 122 ++++++++++++
 4 files changed

// File: rtl/pila_pkg.sv
// pila_pkg: shared defaults and {push,pop} operation encoding for the return-address stack
package pila_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 8;
  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } op_e;
  function automatic op_e decode_op(input logic push, input logic pop);
    return op_e'({push, pop});
  endfunction
endpackage

// File: rtl/pila_mem.sv
// pila_mem: unreset register array with one synchronous write port and one combinational read port
module pila_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  // write the addressed entry on the clock edge
  always_ff @(posedge clk)
    if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/pila_retorno.sv
// pila_retorno: LIFO of return addresses with count, full/empty and sticky overflow/underflow flags
module pila_retorno
  import pila_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);
  localparam int AW = $clog2(DEPTH);
  logic [CW-1:0]    sp_q, sp_d, sp_m1;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] rdata;
  op_e              op;
  assign sp_m1 = sp_q - CW'(1);
  assign empty = sp_q == '0;
  assign full  = sp_q == CW'(DEPTH);
  assign op    = decode_op(push, pop);
  pila_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (din),
    .raddr (sp_m1[AW-1:0]),
    .rdata (rdata)
  );
  // priority: clear, then replace/push/pop; an empty replace still stores into slot 0
  always_comb begin
    sp_d  = sp_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    we    = 1'b0;
    waddr = sp_q[AW-1:0];
    if (clear) begin
      sp_d  = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      case (op)
        OP_REPLACE: begin
          we    = 1'b1;
          waddr = empty ? '0 : sp_m1[AW-1:0];
          sp_d  = empty ? CW'(1) : sp_q;
          unf_d = unf_q | empty;
        end
        OP_PUSH: begin
          we    = !full;
          sp_d  = full ? sp_q : sp_q + CW'(1);
          ovf_d = ovf_q | full;
        end
        OP_POP: begin
          sp_d  = empty ? sp_q : sp_m1;
          unf_d = unf_q | empty;
        end
        default: ;
      endcase
    end
  end
  // stack pointer and sticky flags
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  assign top       = empty ? '0 : rdata;
  assign count     = sp_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
endmodule

// File: tb/tb_pila_retorno.sv
// tb_pila_retorno: table-driven scoreboard bench for the return-address stack
module tb_pila_retorno;
  localparam int W  = 8;
  localparam int D  = 8;
  localparam int CW = 4;
  logic          clk = 1'b0, reset = 1'b1, clear = 1'b0, push = 1'b0, pop = 1'b0;
  logic [W-1:0]  din = '0;
  logic [W-1:0]  top;
  logic [CW-1:0] count;
  logic          empty, full, overflow, underflow;
  int total = 0, bad = 0;
  typedef struct {
    logic       pu, po, cl;
    logic [7:0] d;
    logic [7:0] t;
    int         c;
    logic       em, fu, ov, un;
  } vec_t;
  vec_t vecs[$];
  vec_t sb[$];
  always #5 clk = ~clk;
  pila_retorno #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .push      (push),
    .pop       (pop),
    .din       (din),
    .top       (top),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask
  function automatic vec_t v(input logic pu, input logic po, input logic cl, input logic [7:0] d,
                             input logic [7:0] t, input int c, input logic em, input logic fu,
                             input logic ov, input logic un);
    vec_t r;
    r.pu = pu; r.po = po; r.cl = cl; r.d = d; r.t = t; r.c = c;
    r.em = em; r.fu = fu; r.ov = ov; r.un = un;
    return r;
  endfunction
  task automatic check_state(input string tag, input vec_t e);
    chk({tag, ".top"}, 32'(top), 32'(e.t));
    chk({tag, ".count"}, 32'(count), 32'(e.c));
    chk({tag, ".empty"}, 32'(empty), 32'(e.em));
    chk({tag, ".full"}, 32'(full), 32'(e.fu));
    chk({tag, ".overflow"}, 32'(overflow), 32'(e.ov));
    chk({tag, ".underflow"}, 32'(underflow), 32'(e.un));
  endtask
  task automatic apply(input string tag, input vec_t e);
    vec_t got;
    @(negedge clk);
    push = e.pu; pop = e.po; clear = e.cl; din = e.d;
    sb.push_back(e);
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; clear = 1'b0;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      got = sb.pop_front();
      check_state(tag, got);
    end
  endtask
  initial begin
    vecs.push_back(v(1,0,0,8'h11, 8'h11,1,0,0,0,0));
    vecs.push_back(v(1,0,0,8'h22, 8'h22,2,0,0,0,0));
    vecs.push_back(v(1,0,0,8'h33, 8'h33,3,0,0,0,0));
    vecs.push_back(v(0,1,0,8'h00, 8'h22,2,0,0,0,0));
    vecs.push_back(v(0,1,0,8'h00, 8'h11,1,0,0,0,0));
    vecs.push_back(v(0,1,0,8'h00, 8'h00,0,1,0,0,0));
    for (int i = 1; i <= 8; i++)
      vecs.push_back(v(1,0,0,8'(i), 8'(i),i,0,(i == 8),0,0));
    vecs.push_back(v(1,0,0,8'hFF, 8'h08,8,0,1,1,0));
    vecs.push_back(v(0,1,0,8'h00, 8'h07,7,0,0,1,0));
    vecs.push_back(v(1,0,1,8'h77, 8'h00,0,1,0,0,0));
    vecs.push_back(v(1,0,0,8'h40, 8'h40,1,0,0,0,0));
    vecs.push_back(v(1,1,0,8'h55, 8'h55,1,0,0,0,0));
    vecs.push_back(v(0,1,0,8'h00, 8'h00,0,1,0,0,0));
    vecs.push_back(v(1,1,0,8'h55, 8'h55,1,0,0,0,1));
    vecs.push_back(v(0,0,1,8'h00, 8'h00,0,1,0,0,0));
    vecs.push_back(v(0,1,0,8'h00, 8'h00,0,1,0,0,1));
    vecs.push_back(v(0,0,0,8'h00, 8'h00,0,1,0,0,1));
    vecs.push_back(v(0,0,1,8'h00, 8'h00,0,1,0,0,0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_state("reset", v(0,0,0,0, 8'h00,0,1,0,0,0));
    @(posedge clk);
    #1;
    check_state("idle", v(0,0,0,0, 8'h00,0,1,0,0,0));
    for (int i = 0; i < vecs.size(); i++)
      apply($sformatf("v%0d", i), vecs[i]);
    apply("pre_aa", v(1,0,0,8'hAA, 8'hAA,1,0,0,0,0));
    apply("pre_bb", v(1,0,0,8'hBB, 8'hBB,2,0,0,0,0));
    @(negedge clk);
    push = 1'b1; din = 8'hDD;
    #2;
    reset = 1'b1;
    #1;
    check_state("async_rst", v(0,0,0,0, 8'h00,0,1,0,0,0));
    @(negedge clk);
    push = 1'b0;
    reset = 1'b0;
    #1;
    check_state("post_rst", v(0,0,0,0, 8'h00,0,1,0,0,0));
    apply("after_cc", v(1,0,0,8'hCC, 8'hCC,1,0,0,0,0));
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
